nasti_stream_tx: RTL and testbench

NASTI_STREAM_TX -- requirements
Module: nasti_stream_tx

---
 rtl/nasti_stream_tx_if.sv | 29 ++
 rtl/nasti_stream_tx.sv | 192 +++++++++++++++++++
 tb/tb_nasti_stream_tx.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nasti_stream_tx_if.sv
// nasti_stream_channel: AXI-stream style channel bundle.
//   master drives t_valid/t_data/t_strb/t_keep/t_last/t_id/t_user,
//   slave drives t_ready.
interface nasti_stream_channel #(
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned USER_WIDTH = 1
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    logic                  t_valid;
    logic                  t_ready;
    logic [DATA_WIDTH-1:0] t_data;
    logic [STRB_W-1:0]     t_strb;
    logic [STRB_W-1:0]     t_keep;
    logic                  t_last;
    logic [ID_WIDTH-1:0]   t_id;
    logic [USER_WIDTH-1:0] t_user;

    modport master (
        output t_valid, t_data, t_strb, t_keep, t_last, t_id, t_user,
        input  t_ready
    );

    modport slave (
        input  t_valid, t_data, t_strb, t_keep, t_last, t_id, t_user,
        output t_ready
    );
endinterface

// File: rtl/nasti_stream_tx.sv
// nasti_stream_tx: buffers pushed words in a small FIFO and emits them as one
// stream packet of pkt_len beats, with t_last on the final beat.
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   start, pkt_len,    packet request; length/id/user latched on acceptance
//   pkt_id, pkt_user
//   last_keep          (only with NASTI_STREAM_TX_KEEP_EN) keep/strb for last beat
//   wr_valid/wr_data/  word push handshake
//   wr_ready
//   busy, done         packet in progress / one-cycle end-of-packet pulse
//   tx                 stream master channel
// Optional feature macro: NASTI_STREAM_TX_KEEP_EN.
module nasti_stream_tx #(
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [15:0]           pkt_len,
    input  logic [ID_WIDTH-1:0]   pkt_id,
    input  logic [USER_WIDTH-1:0] pkt_user,
`ifdef NASTI_STREAM_TX_KEEP_EN
    input  logic [DATA_WIDTH/8-1:0] last_keep,
`endif
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic                  busy,
    output logic                  done,
    nasti_stream_channel.master   tx
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned LEN_W  = 16;

    typedef enum logic {IDLE, RUN} state_e;

    state_e                state_q, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [USER_WIDTH-1:0] user_q, user_d;
    logic [LEN_W-1:0]      in_cnt_q, in_cnt_d;
    logic [LEN_W-1:0]      out_cnt_q, out_cnt_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  wr_ready_q, wr_ready_d;
    logic                  done_q, done_d;
    logic [STRB_W-1:0]     keep_q, keep_d;
`ifdef NASTI_STREAM_TX_KEEP_EN
    logic [STRB_W-1:0]     lkeep_q, lkeep_d;
`endif

    logic push;
    logic pop;

    // wr_ready_q is a flop, so acceptance never loops back through wr_valid
    assign push = wr_valid && wr_ready_q;
    assign pop  = valid_q && tx.t_ready;

    // State and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            len_q      <= '0;
            id_q       <= '0;
            user_q     <= '0;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            wr_ready_q <= 1'b0;
            done_q     <= 1'b0;
            keep_q     <= '0;
`ifdef NASTI_STREAM_TX_KEEP_EN
            lkeep_q    <= '0;
`endif
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            id_q       <= id_d;
            user_q     <= user_d;
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            wr_ready_q <= wr_ready_d;
            done_q     <= done_d;
            keep_q     <= keep_d;
`ifdef NASTI_STREAM_TX_KEEP_EN
            lkeep_q    <= lkeep_d;
`endif
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Next-state, FIFO bookkeeping and next values of the registered outputs
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        id_d      = id_q;
        user_d    = user_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        mem_d     = mem_q;
        done_d    = 1'b0;
`ifdef NASTI_STREAM_TX_KEEP_EN
        lkeep_d   = lkeep_q;
`endif

        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            in_cnt_d        = in_cnt_q + LEN_W'(1);
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            out_cnt_d = out_cnt_q + LEN_W'(1);
        end
        // Push and pop together leave occupancy unchanged
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        case (state_q)
            IDLE: begin
                if (start && (pkt_len != '0)) begin
                    state_d   = RUN;
                    len_d     = pkt_len;
                    id_d      = pkt_id;
                    user_d    = pkt_user;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
`ifdef NASTI_STREAM_TX_KEEP_EN
                    lkeep_d   = last_keep;
`endif
                end
            end
            RUN: begin
                if (pop && last_q) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are computed one cycle early from next-state values
        wr_ready_d = (state_d == RUN) && (count_d < CNT_W'(DEPTH)) && (in_cnt_d < len_d);
        valid_d    = (count_d != '0);
        last_d     = (state_d == RUN) && valid_d && (out_cnt_d == len_d - LEN_W'(1));
        keep_d     = '1;
`ifdef NASTI_STREAM_TX_KEEP_EN
        if (last_d) begin
            keep_d = lkeep_d;
        end
`endif
    end

    assign wr_ready   = wr_ready_q;
    assign busy       = (state_q == RUN);
    assign done       = done_q;
    assign tx.t_valid = valid_q;
    // Head word is masked while empty so idle/reset data reads as zero
    assign tx.t_data  = valid_q ? mem_q[rd_ptr_q] : '0;
    assign tx.t_strb  = keep_q;
    assign tx.t_keep  = keep_q;
    assign tx.t_last  = last_q;
    assign tx.t_id    = id_q;
    assign tx.t_user  = user_q;
endmodule

// File: tb/tb_nasti_stream_tx.sv
module tb_nasti_stream_tx;
    localparam int unsigned DW    = 64;
    localparam int unsigned IW    = 1;
    localparam int unsigned UW    = 1;
    localparam int unsigned DEPTH = 4;

    logic          clk;
    logic          rstn;
    logic          start;
    logic [15:0]   pkt_len;
    logic [IW-1:0] pkt_id;
    logic [UW-1:0] pkt_user;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          busy;
    logic          done;
`ifdef NASTI_STREAM_TX_KEEP_EN
    logic [7:0]    last_keep;
`endif

    int errors = 0;
    int checks = 0;

    logic [63:0]   bq_data [$];
    logic          bq_last [$];
    logic [IW-1:0] bq_id   [$];
    logic [7:0]    bq_keep [$];
    logic [7:0]    bq_strb [$];

    nasti_stream_channel #(.ID_WIDTH(IW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) tx_if ();

    nasti_stream_tx #(
        .ID_WIDTH(IW), .DATA_WIDTH(DW), .USER_WIDTH(UW), .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .pkt_len  (pkt_len),
        .pkt_id   (pkt_id),
        .pkt_user (pkt_user),
`ifdef NASTI_STREAM_TX_KEEP_EN
        .last_keep(last_keep),
`endif
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .busy     (busy),
        .done     (done),
        .tx       (tx_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted beat
    always @(posedge clk) begin
        if (tx_if.t_valid === 1'b1 && tx_if.t_ready === 1'b1) begin
            bq_data.push_back(tx_if.t_data);
            bq_last.push_back(tx_if.t_last);
            bq_id.push_back(tx_if.t_id);
            bq_keep.push_back(tx_if.t_keep);
            bq_strb.push_back(tx_if.t_strb);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        bq_data.delete();
        bq_last.delete();
        bq_id.delete();
        bq_keep.delete();
        bq_strb.delete();
    endtask

    // Push n words base, base+1, ... honouring wr_ready
    task automatic push_n(input string tag, input int n, input logic [63:0] base);
        int   pushed;
        int   budget;
        logic acc;
        pushed = 0;
        budget = 0;
        while (pushed < n && budget < 64) begin
            wr_valid = 1'b1;
            wr_data  = base + 64'(pushed);
            acc      = wr_ready;
            step();
            if (acc === 1'b1) pushed++;
            budget++;
        end
        wr_valid = 1'b0;
        chk(tag, 64'(pushed), 64'(n));
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk(tag, 64'(done), 64'd1);
    endtask

    task automatic begin_pkt(input logic [15:0] len, input logic [IW-1:0] id);
        start   = 1'b1;
        pkt_len = len;
        pkt_id  = id;
        step();
        start   = 1'b0;
    endtask

    initial begin
        rstn           = 1'b0;
        start          = 1'b0;
        pkt_len        = '0;
        pkt_id         = '0;
        pkt_user       = '0;
        wr_valid       = 1'b0;
        wr_data        = '0;
        tx_if.t_ready  = 1'b0;
`ifdef NASTI_STREAM_TX_KEEP_EN
        last_keep      = 8'hFF;
`endif

        // Reset state
        step();
        chk("rst_valid",    64'(tx_if.t_valid), 64'd0);
        chk("rst_last",     64'(tx_if.t_last),  64'd0);
        chk("rst_wr_ready", 64'(wr_ready),      64'd0);
        chk("rst_busy",     64'(busy),          64'd0);
        chk("rst_done",     64'(done),          64'd0);
        chk("rst_data",     tx_if.t_data,       64'd0);
        rstn = 1'b1;
        step();
        step();

        // Basic packet: len 3, id 1, exact cycle behaviour
        clear_q();
        tx_if.t_ready = 1'b1;
        pkt_user      = 1'b1;
        begin_pkt(16'd3, 1'b1);
        chk("b_busy",     64'(busy),          64'd1);
        chk("b_wr_ready", 64'(wr_ready),      64'd1);
        chk("b_valid0",   64'(tx_if.t_valid), 64'd0);
        chk("b_id",       64'(tx_if.t_id),    64'd1);
        chk("b_user",     64'(tx_if.t_user),  64'd1);
        wr_valid = 1'b1;
        wr_data  = 64'hA;
        step();
        chk("b_lat_valid", 64'(tx_if.t_valid), 64'd1);
        chk("b_dA",        tx_if.t_data,       64'hA);
        chk("b_lastA",     64'(tx_if.t_last),  64'd0);
        wr_data = 64'hB;
        step();
        chk("b_dB",    tx_if.t_data,      64'hB);
        chk("b_lastB", 64'(tx_if.t_last), 64'd0);
        wr_data = 64'hC;
        step();
        wr_valid = 1'b0;
        chk("b_dC",       tx_if.t_data,      64'hC);
        chk("b_lastC",    64'(tx_if.t_last), 64'd1);
        chk("b_rdy_full", 64'(wr_ready),     64'd0);
        step();
        chk("b_done",    64'(done),          64'd1);
        chk("b_busy_lo", 64'(busy),          64'd0);
        chk("b_valid_e", 64'(tx_if.t_valid), 64'd0);
        step();
        chk("b_done_1c", 64'(done),          64'd0);
        chk("b_nbeats",  64'(bq_data.size()), 64'd3);
        if (bq_data.size() == 3) begin
            chk("b_beat0", {bq_data[0][62:0], bq_last[0]}, {63'hA, 1'b0});
            chk("b_beat1", {bq_data[1][62:0], bq_last[1]}, {63'hB, 1'b0});
            chk("b_beat2", {bq_data[2][62:0], bq_last[2]}, {63'hC, 1'b1});
            chk("b_beat_id", 64'(bq_id[2]), 64'd1);
        end
        pkt_user = 1'b0;

        // Backpressure: len 8 with a stalled sink fills 4 entries
        clear_q();
        tx_if.t_ready = 1'b0;
        begin_pkt(16'd8, 1'b0);
        push_n("bp_push4", 4, 64'h100);
        chk("bp_rdy_lo", 64'(wr_ready), 64'd0);
        step();
        step();
        chk("bp_rdy_still_lo", 64'(wr_ready),      64'd0);
        chk("bp_hold_valid",   64'(tx_if.t_valid), 64'd1);
        chk("bp_hold_data",    tx_if.t_data,       64'h100);
        chk("bp_hold_last",    64'(tx_if.t_last),  64'd0);
        tx_if.t_ready = 1'b1;
        push_n("bp_push_rest", 4, 64'h104);
        wait_done("bp_done");
        chk("bp_nbeats", 64'(bq_data.size()), 64'd8);
        if (bq_data.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("bp_data", bq_data[i], 64'h100 + 64'(i));
                chk("bp_last", 64'(bq_last[i]), (i == 7) ? 64'd1 : 64'd0);
`ifndef NASTI_STREAM_TX_KEEP_EN
                chk("bp_keep", {48'd0, bq_keep[i], bq_strb[i]}, 64'hFFFF);
`endif
            end
        end
        step();

        // Zero length start, then a start during RUN
        clear_q();
        begin_pkt(16'd0, 1'b1);
        chk("z_busy",  64'(busy),     64'd0);
        chk("z_ready", 64'(wr_ready), 64'd0);
        begin_pkt(16'd2, 1'b0);
        chk("z_busy_run", 64'(busy), 64'd1);
        begin_pkt(16'd5, 1'b1);
        chk("z_id_kept", 64'(tx_if.t_id), 64'd0);
        push_n("z_push2", 2, 64'h200);
        wait_done("z_done");
        chk("z_nbeats", 64'(bq_data.size()), 64'd2);
        if (bq_data.size() == 2) begin
            chk("z_last", {62'd0, bq_last[0], bq_last[1]}, 64'b01);
        end
        step();
        chk("z_idle", 64'(busy), 64'd0);

        // Reset mid-packet: 2 beats out, 1 buffered, then reset
        clear_q();
        begin_pkt(16'd4, 1'b0);
        push_n("r_push2", 2, 64'h300);
        step();
        tx_if.t_ready = 1'b0;
        push_n("r_push1", 1, 64'h302);
        chk("r_buffered", 64'(tx_if.t_valid), 64'd1);
        chk("r_out2", 64'(bq_data.size()), 64'd2);
        rstn = 1'b0;
        #1;
        chk("r_valid", 64'(tx_if.t_valid), 64'd0);
        chk("r_busy",  64'(busy),          64'd0);
        chk("r_rdy",   64'(wr_ready),      64'd0);
        chk("r_data",  tx_if.t_data,       64'd0);
        step();
        rstn = 1'b1;
        step();
        step();
        chk("r_post_valid", 64'(tx_if.t_valid), 64'd0);
        chk("r_post_busy",  64'(busy),          64'd0);
        chk("r_no_last",    64'(bq_last.size() == 2 && bq_last[1] == 1'b0), 64'd1);
        tx_if.t_ready = 1'b1;
        begin_pkt(16'd1, 1'b1);
        chk("r_new_last", 64'(tx_if.t_last), 64'd0);
        push_n("r_push_new", 1, 64'h3AA);
        wait_done("r_done");
        chk("r_nbeats", 64'(bq_data.size()), 64'd3);
        if (bq_data.size() == 3) begin
            chk("r_beat", {bq_data[2][62:0], bq_last[2]}, {63'h3AA, 1'b1});
        end

        // Back-to-back: second start one cycle after done
        clear_q();
        begin_pkt(16'd1, 1'b0);
        push_n("bb_push0", 1, 64'h400);
        wait_done("bb_done0");
        step();
        begin_pkt(16'd1, 1'b1);
        chk("bb_busy", 64'(busy),       64'd1);
        chk("bb_id",   64'(tx_if.t_id), 64'd1);
        push_n("bb_push1", 1, 64'h401);
        wait_done("bb_done1");
        chk("bb_nbeats", 64'(bq_data.size()), 64'd2);
        if (bq_data.size() == 2) begin
            chk("bb_ids", {62'd0, bq_id[0], bq_id[1]}, 64'b01);
            chk("bb_data1", bq_data[1], 64'h401);
        end

`ifdef NASTI_STREAM_TX_KEEP_EN
        // Last-beat keep/strb
        clear_q();
        step();
        last_keep = 8'h0F;
        begin_pkt(16'd2, 1'b0);
        last_keep = 8'hFF;
        push_n("k_push", 2, 64'h500);
        wait_done("k_done");
        chk("k_nbeats", 64'(bq_data.size()), 64'd2);
        if (bq_data.size() == 2) begin
            chk("k_beat0", {48'd0, bq_keep[0], bq_strb[0]}, 64'hFFFF);
            chk("k_beat1", {48'd0, bq_keep[1], bq_strb[1]}, 64'h0F0F);
        end
`endif

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
